div_16x8_seq: RTL and testbench

- Sequential radix-2 restoring divider: 16-bit dividend / 8-bit divisor -> 16-bit quotient, 8-bit remainder.
- Inverse-direction companion to the 8x8 multiplier family: recovers an operand from a 16-bit product.
- Used for error-characterisation and inverse-check paths of the approximate multipliers.
- Valid/ready handshake on both sides; one quotient bit per cycle.

---
 rtl/div_16x8_seq.sv | 110 +++++++++++
 tb/tb_div_16x8_seq.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/div_16x8_seq.sv
// rtl/div_16x8_seq.sv - sequential 16/8 restoring divider, one quotient bit per cycle, valid/ready on both sides
// Optional truncated-quotient mode enabled by defining APPROX_DIV_EN (skips TRUNC_BITS low quotient bits).
module div_16x8_seq #(
  parameter int TRUNC_BITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] quotient,
  output logic [7:0]  remainder,
  output logic        div_by_zero
);

`ifdef APPROX_DIV_EN
  localparam bit APPROX = 1'b1;
`else
  localparam bit APPROX = 1'b0;
`endif

  // Number of low quotient bits that are never computed; zero in the exact build.
  localparam int         SKIP     = APPROX ? TRUNC_BITS : 0;
  localparam logic [3:0] CNT_LOAD = 4'(15 - SKIP);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [15:0] dvd_sh;
  logic [7:0]  dvs;
  logic [8:0]  p;
  logic [14:0] q;

  logic [8:0]  p_sh;
  logic [8:0]  p_next;
  logic        q_bit;
  logic [15:0] q_next;

  // One restoring step: shift the next dividend bit into the 9-bit partial remainder, then trial-subtract.
  always_comb begin
    p_sh   = 9'({p, dvd_sh[15]});
    q_bit  = (p_sh >= {1'b0, dvs});
    p_next = q_bit ? (p_sh - {1'b0, dvs}) : p_sh;
    q_next = {q, q_bit};
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      dvd_sh      <= 16'd0;
      dvs         <= 8'd0;
      p           <= 9'd0;
      q           <= 15'd0;
      quotient    <= 16'd0;
      remainder   <= 8'd0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (divisor == 8'd0) begin
              quotient    <= 16'hFFFF;
              remainder   <= dividend[7:0];
              div_by_zero <= 1'b1;
              state       <= DONE;
            end else begin
              dvd_sh      <= dividend;
              dvs         <= divisor;
              p           <= 9'd0;
              q           <= 15'd0;
              cnt         <= CNT_LOAD;
              div_by_zero <= 1'b0;
              state       <= CALC;
            end
          end
        end
        CALC: begin
          dvd_sh <= {dvd_sh[14:0], 1'b0};
          p      <= p_next;
          q      <= q_next[14:0];
          if (cnt == 4'd0) begin
            // Truncated mode: computed bits sit low in q_next and are realigned to the top.
            quotient  <= q_next << SKIP;
            remainder <= APPROX ? 8'd0 : p_next[7:0];
            state     <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_16x8_seq.sv
// tb/tb_div_16x8_seq.sv - randomized self-checking bench for div_16x8_seq against an arithmetic reference model
// Expectations follow APPROX_DIV_EN when it is defined for the build.
module tb_div_16x8_seq;

  localparam int TRUNC = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  int nvec = 0;
  int nerr = 0;

  div_16x8_seq #(.TRUNC_BITS(TRUNC)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Expected result and latency (cycles from accept to first out_valid) from plain arithmetic.
  function automatic void model(input logic [15:0] a, input logic [7:0] b,
                                output logic [15:0] eq, output logic [7:0] er,
                                output logic ez, output int elat);
    if (b == 8'd0) begin
      eq = 16'hFFFF; er = a[7:0]; ez = 1'b1; elat = 1;
    end else begin
      ez = 1'b0;
`ifdef APPROX_DIV_EN
      eq = 16'(((a >> TRUNC) / b) << TRUNC);
      er = 8'd0;
      elat = 17 - TRUNC;
`else
      eq = a / b;
      er = 8'(a % b);
      elat = 17;
`endif
    end
  endfunction

  // Drive one operand pair; returns #1 after the accepting edge with garbage left on the inputs.
  task automatic send(input logic [15:0] a, input logic [7:0] b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'($urandom);
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
  endtask

  task automatic wait_out(output int lat, output bit rdy_seen, output bit to);
    lat = 1; rdy_seen = 1'b0; to = 1'b0;
    while (!out_valid) begin
      if (in_ready) rdy_seen = 1'b1;
      if (lat >= 40) begin
        to = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    if (in_ready) rdy_seen = 1'b1;
  endtask

  task automatic take();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  // Runs one full transaction with immediate retirement and checks everything observable.
  task automatic run_checked(input string name, input logic [15:0] a, input logic [7:0] b);
    logic [15:0] eq; logic [7:0] er; logic ez; int elat;
    int lat; bit rdy_seen; bit to;
    model(a, b, eq, er, ez, elat);
    send(a, b);
    wait_out(lat, rdy_seen, to);
    nvec++;
    if (to) begin
      nerr++;
      $display("FAIL %s timeout: out_valid never rose for %0d/%0d", name, a, b);
    end
    nvec++;
    if ({quotient, remainder, div_by_zero} !== {eq, er, ez}) begin
      nerr++;
      $display("FAIL %s result %0d/%0d: got q=%0d r=%0d z=%0b expected q=%0d r=%0d z=%0b",
               name, a, b, quotient, remainder, div_by_zero, eq, er, ez);
    end
    nvec++;
    if (lat !== elat) begin
      nerr++;
      $display("FAIL %s latency %0d/%0d: got %0d expected %0d", name, a, b, lat, elat);
    end
    nvec++;
    if (rdy_seen !== 1'b0) begin
      nerr++;
      $display("FAIL %s in_ready: got high during operation expected low", name);
    end
    take();
    nvec++;
    if ({in_ready, out_valid} !== 2'b10) begin
      nerr++;
      $display("FAIL %s retire: got in_ready=%0b out_valid=%0b expected 1 0", name, in_ready, out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; dividend = 16'd0; divisor = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    nvec++;
    if ({in_ready, out_valid, quotient, remainder, div_by_zero} !== {1'b1, 1'b0, 16'd0, 8'd0, 1'b0}) begin
      nerr++;
      $display("FAIL reset: got in_ready=%0b out_valid=%0b q=%0d r=%0d z=%0b expected 1 0 0 0 0",
               in_ready, out_valid, quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    run_checked("basic", 16'd1000, 8'd7);
  endtask

  task automatic test_back_to_back();
    run_checked("b2b_first", 16'd65535, 8'd1);
    run_checked("b2b_second", 16'd65025, 8'd255);
  endtask

  task automatic test_div_zero();
    run_checked("div_zero", 16'd100, 8'd0);
    run_checked("div_zero_max", 16'hFFFF, 8'd0);
  endtask

  task automatic test_backpressure();
    logic [15:0] eq; logic [7:0] er; logic ez; int elat;
    int lat; bit rdy_seen; bit to;
    model(16'd5, 8'd9, eq, er, ez, elat);
    send(16'd5, 8'd9);
    wait_out(lat, rdy_seen, to);
    nvec++;
    if (to || lat !== elat) begin
      nerr++;
      $display("FAIL bp latency: got %0d (timeout=%0b) expected %0d", lat, to, elat);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      nvec++;
      if ({out_valid, in_ready, quotient, remainder, div_by_zero} !== {1'b1, 1'b0, eq, er, ez}) begin
        nerr++;
        $display("FAIL bp hold cycle %0d: got v=%0b rdy=%0b q=%0d r=%0d z=%0b expected 1 0 %0d %0d %0b",
                 i, out_valid, in_ready, quotient, remainder, div_by_zero, eq, er, ez);
      end
      in_valid = i[0];
      dividend = 16'($urandom);
      divisor  = 8'($urandom);
    end
    @(negedge clk);
    take();
    nvec++;
    if ({in_ready, out_valid} !== 2'b10) begin
      nerr++;
      $display("FAIL bp retire: got in_ready=%0b out_valid=%0b expected 1 0", in_ready, out_valid);
    end
    run_checked("bp_next", 16'd5, 8'd9);
  endtask

  task automatic test_reset_mid();
    bit seen;
    send(16'd40000, 8'd3);
    repeat (5) @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    nvec++;
    if ({in_ready, out_valid} !== 2'b10) begin
      nerr++;
      $display("FAIL reset_mid: got in_ready=%0b out_valid=%0b expected 1 0", in_ready, out_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    nvec++;
    if (seen !== 1'b0) begin
      nerr++;
      $display("FAIL reset_mid discard: got out_valid after reset expected none");
    end
    run_checked("reset_mid_next", 16'd40000, 8'd3);
  endtask

  task automatic test_random();
    logic [15:0] eq; logic [7:0] er; logic ez; int elat;
    logic [15:0] a; logic [7:0] b;
    int lat; bit rdy_seen; bit to; int hold;
    for (int n = 0; n < 150; n++) begin
      a = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 300)) : 16'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      model(a, b, eq, er, ez, elat);
      send(a, b);
      wait_out(lat, rdy_seen, to);
      nvec++;
      if (to || lat !== elat || rdy_seen) begin
        nerr++;
        $display("FAIL rand %0d timing %0d/%0d: got lat=%0d timeout=%0b rdy=%0b expected lat=%0d",
                 n, a, b, lat, to, rdy_seen, elat);
      end
      hold = $urandom_range(0, 3);
      repeat (hold) @(posedge clk);
      #1;
      nvec++;
      if ({out_valid, quotient, remainder, div_by_zero} !== {1'b1, eq, er, ez}) begin
        nerr++;
        $display("FAIL rand %0d result %0d/%0d: got v=%0b q=%0d r=%0d z=%0b expected q=%0d r=%0d z=%0b",
                 n, a, b, out_valid, quotient, remainder, div_by_zero, eq, er, ez);
      end
      take();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_div_zero();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
